oht2bin_pipe: RTL and testbench

OHT2BIN_PIPE -- requirements
Module: oht2bin_pipe

---
 rtl/oht2bin_pkg.sv | 30 +++
 rtl/oht2bin_pipe_node.sv | 63 ++++++
 rtl/oht2bin_pipe.sv | 143 ++++++++++++++
 tb/tb_oht2bin_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oht2bin_pkg.sv
// Shared sizing helpers and stage record for the oht2bin one-hot-to-binary tree.
package oht2bin_pkg;

  localparam int IDX_MAX = 32;

  typedef struct packed {
    logic               vld;
    logic [IDX_MAX-1:0] idx;
    logic               err;
  } stage_t;

  // Number of tree levels: ceil(clog2(width) / clog2(split)), never below one.
  function automatic int tree_levels(input int width, input int split);
    int wl;
    int sl;
    int lv;
    wl = $clog2(width);
    sl = (split > 1) ? $clog2(split) : 1;
    lv = (wl + sl - 1) / sl;
    return (lv < 1) ? 1 : lv;
  endfunction

  function automatic int tree_power(input int width, input int split);
    int p;
    p = 1;
    for (int i = 0; i < tree_levels(width, split); i++) p = p * split;
    return p;
  endfunction

endpackage

// File: rtl/oht2bin_pipe_node.sv
// One combinational SPLIT-way tree node: ORs child valids and prepends the valid child's number to the ORed child indices.
// err ports exist only when ONEHOT_CHECK_EN is defined.
module oht2bin_pipe_node
  import oht2bin_pkg::*;
#(
  parameter int SPLIT = 2,
  parameter int IDX_W = 0
) (
  input  logic [SPLIT-1:0]                           vld_i,
  input  logic [SPLIT*((IDX_W > 0) ? IDX_W : 1)-1:0] idx_i,
`ifdef ONEHOT_CHECK_EN
  input  logic [SPLIT-1:0]                           err_i,
  output logic                                       err_o,
`endif
  output logic                                       vld_o,
  output logic [IDX_W+$clog2(SPLIT)-1:0]             idx_o
);

  localparam int SPLIT_LOG = $clog2(SPLIT);
  localparam int IDX_P     = (IDX_W > 0) ? IDX_W : 1;

  logic [SPLIT_LOG-1:0] sel;
  logic [IDX_P-1:0]     idx_or;

  // Multi-hot children OR their numbers together, matching the whole-vector OR rule.
  always_comb begin
    sel    = '0;
    idx_or = '0;
    vld_o  = 1'b0;
    for (int i = 0; i < SPLIT; i++) begin
      if (vld_i[i]) sel = sel | SPLIT_LOG'(i);
      idx_or = idx_or | idx_i[i*IDX_P +: IDX_P];
      vld_o  = vld_o | vld_i[i];
    end
  end

  if (IDX_W > 0) begin : g_inner
    assign idx_o = {sel, idx_or};
  end else begin : g_leaf
    logic unused_idx;
    assign unused_idx = |idx_or;
    assign idx_o      = sel;
  end

`ifdef ONEHOT_CHECK_EN
  logic multi;
  logic seen;

  always_comb begin
    multi = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < SPLIT; i++) begin
      if (vld_i[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
  end

  assign err_o = multi | (|err_i);
`endif

endmodule

// File: rtl/oht2bin_pipe.sv
// Pipelined one-hot to binary encoder: SPLIT-ary tree, one register stage per level, valid/ready with a combinational ready chain.
// Define ONEHOT_CHECK_EN to flag multi-hot inputs on err; otherwise err is tied low and no err registers exist.
module oht2bin_pipe
  import oht2bin_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPLIT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_vld,
  output logic                     s_rdy,
  input  logic [WIDTH-1:0]         oht,
  output logic                     m_vld,
  input  logic                     m_rdy,
  output logic [$clog2(WIDTH)-1:0] bin,
  output logic                     vld,
  output logic                     err
);

  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int SPLIT_LOG = $clog2(SPLIT);
  localparam int LEVELS    = tree_levels(WIDTH, SPLIT);
  localparam int POWER     = tree_power(WIDTH, SPLIT);

  if (WIDTH < 2) begin : g_bad_width
    $error("oht2bin_pipe: WIDTH must be 2 or more");
  end
  if (SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
    $error("oht2bin_pipe: SPLIT must be a power of 2, 2 or more");
  end

  logic [LEVELS:0]   stg_rdy;
  logic [LEVELS-1:0] stg_in_vld;
  logic [LEVELS-1:0] stg_ld;
  logic [LEVELS-1:0] stg_vld_d;
  logic [LEVELS-1:0] stg_vld_q;

  // A stage accepts when empty or when its downstream neighbour accepts this cycle.
  always_comb begin
    stg_rdy         = '0;
    stg_rdy[LEVELS] = m_rdy;
    for (int k = LEVELS - 1; k >= 0; k--) stg_rdy[k] = ~stg_vld_q[k] | stg_rdy[k+1];
  end

  always_comb begin
    stg_in_vld    = '0;
    stg_in_vld[0] = s_vld;
    for (int k = 1; k < LEVELS; k++) stg_in_vld[k] = stg_vld_q[k-1];
  end

  assign stg_ld    = stg_rdy[LEVELS-1:0] & stg_in_vld;
  assign stg_vld_d = stg_ld | (~stg_rdy[LEVELS-1:0] & stg_vld_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg_vld_q <= '0;
    else        stg_vld_q <= stg_vld_d;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_stg
    localparam int NN  = POWER / (SPLIT ** (l + 1));
    localparam int IWI = l * SPLIT_LOG;
    localparam int IWP = (IWI > 0) ? IWI : 1;
    localparam int IWO = (l + 1) * SPLIT_LOG;

    logic [NN*SPLIT-1:0]     cv;
    logic [NN*SPLIT*IWP-1:0] ci;
    logic [NN-1:0]           nv_d;
    logic [NN-1:0]           nv_q;
    logic [NN*IWO-1:0]       ni_d;
    logic [NN*IWO-1:0]       ni_q;
`ifdef ONEHOT_CHECK_EN
    logic [NN*SPLIT-1:0]     ce;
    logic [NN-1:0]           ne_d;
    logic [NN-1:0]           ne_q;
`endif

    // Padding leaves above WIDTH are constant zero and drop out of every OR.
    if (l == 0) begin : g_src
      assign cv = POWER'(oht);
      assign ci = '0;
`ifdef ONEHOT_CHECK_EN
      assign ce = '0;
`endif
    end else begin : g_prev
      assign cv = g_stg[l-1].nv_q;
      assign ci = g_stg[l-1].ni_q;
`ifdef ONEHOT_CHECK_EN
      assign ce = g_stg[l-1].ne_q;
`endif
    end

    for (genvar n = 0; n < NN; n++) begin : g_node
      oht2bin_pipe_node #(
        .SPLIT (SPLIT),
        .IDX_W (IWI)
      ) u_node (
        .vld_i (cv[n*SPLIT +: SPLIT]),
        .idx_i (ci[n*SPLIT*IWP +: SPLIT*IWP]),
`ifdef ONEHOT_CHECK_EN
        .err_i (ce[n*SPLIT +: SPLIT]),
        .err_o (ne_d[n]),
`endif
        .vld_o (nv_d[n]),
        .idx_o (ni_d[n*IWO +: IWO])
      );
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        nv_q <= '0;
        ni_q <= '0;
      end else if (stg_ld[l]) begin
        nv_q <= nv_d;
        ni_q <= ni_d;
      end
    end

`ifdef ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          ne_q <= '0;
      else if (stg_ld[l])  ne_q <= ne_d;
    end
`endif
  end

  assign s_rdy = stg_rdy[0];
  assign m_vld = stg_vld_q[LEVELS-1];
  assign vld   = g_stg[LEVELS-1].nv_q[0];
  assign bin   = g_stg[LEVELS-1].ni_q[WIDTH_LOG-1:0];

  if (LEVELS * SPLIT_LOG > WIDTH_LOG) begin : g_crop
    logic unused_hi;
    assign unused_hi = |g_stg[LEVELS-1].ni_q[LEVELS*SPLIT_LOG-1:WIDTH_LOG];
  end

`ifdef ONEHOT_CHECK_EN
  assign err = g_stg[LEVELS-1].ne_q[0];
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_oht2bin_pipe.sv
// Bench for oht2bin_pipe: a 32-bit binary tree and a 24-bit 4-ary tree checked against a bit-level reference model.
module tb_oht2bin_pipe;
  import oht2bin_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_s_vld, a_s_rdy, a_m_vld, a_m_rdy, a_vld, a_err;
  logic [31:0] a_oht;
  logic [4:0]  a_bin;

  logic        b_s_vld, b_s_rdy, b_m_vld, b_m_rdy, b_vld, b_err;
  logic [23:0] b_oht;
  logic [4:0]  b_bin;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oht2bin_pipe #(.WIDTH(32), .SPLIT(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_vld(a_s_vld), .s_rdy(a_s_rdy), .oht(a_oht),
    .m_vld(a_m_vld), .m_rdy(a_m_rdy), .bin(a_bin), .vld(a_vld), .err(a_err)
  );

  oht2bin_pipe #(.WIDTH(24), .SPLIT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_vld(b_s_vld), .s_rdy(b_s_rdy), .oht(b_oht),
    .m_vld(b_m_vld), .m_rdy(b_m_rdy), .bin(b_bin), .vld(b_vld), .err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: index is the OR of all set-bit positions; err means more than one bit set.
  function automatic stage_t ref_enc(input logic [63:0] x, input int w);
    stage_t r;
    int     cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < w; i++) begin
      if (x[i]) begin
        cnt++;
        r.idx = r.idx | IDX_MAX'(i);
      end
    end
    r.vld = (cnt != 0);
`ifdef ONEHOT_CHECK_EN
    r.err = (cnt > 1);
`endif
    return r;
  endfunction

  function automatic logic [63:0] rand_oht(input int w);
    int          r;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    r    = $urandom_range(0, 9);
    if (r == 0) return 64'd0;
    if (r == 1) return {$urandom, $urandom} & mask;
    return 64'd1 << $urandom_range(0, w - 1);
  endfunction

  function automatic stage_t obs_a();
    stage_t r;
    r.vld = a_vld;
    r.idx = IDX_MAX'(a_bin);
    r.err = a_err;
    return r;
  endfunction

  function automatic stage_t obs_b();
    stage_t r;
    r.vld = b_vld;
    r.idx = IDX_MAX'(b_bin);
    r.err = b_err;
    return r;
  endfunction

  // Present one item with m_rdy high and count clock edges until it appears.
  task automatic lat_a(input string tag, input logic [31:0] x, input int exp_lat);
    int k;
    @(negedge clk);
    a_m_rdy = 1'b1;
    a_s_vld = 1'b1;
    a_oht   = x;
    #1;
    chk({tag, "_s_rdy"}, a_s_rdy, 1);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      a_s_vld = 1'b0;
      a_oht   = '0;
      if (a_m_vld) break;
    end
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_out"}, obs_a(), ref_enc(x, 32));
  endtask

  stage_t exp_q[$];
  stage_t bexp_q[$];
  int     stamp_q[$];
  stage_t held;
  stage_t want;
  logic   hold_pend;
  int     nin, nout, nb, cyc, cnt;

  initial begin
    rst_n   = 1'b0;
    a_s_vld = 1'b0; a_m_rdy = 1'b0; a_oht = '0;
    b_s_vld = 1'b0; b_m_rdy = 1'b0; b_oht = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_m_vld", a_m_vld, 0);
    chk("rst_a_out", obs_a(), 0);
    chk("rst_a_s_rdy", a_s_rdy, 1);
    chk("rst_b_m_vld", b_m_vld, 0);
    chk("rst_b_out", obs_b(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_a_s_rdy", a_s_rdy, 1);
    chk("rel_b_s_rdy", b_s_rdy, 1);

    // Directed items on the 32-bit, 5-level tree.
    lat_a("bit16", 32'h0001_0000, 5);
    chk("bit16_abs", obs_a(), {1'b1, 32'd16, 1'b0});
    lat_a("zero", 32'h0, 5);
    chk("zero_abs", obs_a(), {1'b0, 32'd0, 1'b0});
    lat_a("multi5", 32'h0000_0005, 5);
`ifdef ONEHOT_CHECK_EN
    chk("multi5_abs", obs_a(), {1'b1, 32'd2, 1'b1});
`else
    chk("multi5_abs", obs_a(), {1'b1, 32'd2, 1'b0});
`endif
    lat_a("bit31", 32'h8000_0000, 5);

    // 24-bit 4-ary tree: every single bit, then random patterns, back to back.
    b_m_rdy = 1'b1;
    nb      = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c < 24) begin
        b_s_vld = 1'b1;
        b_oht   = 24'd1 << c;
      end else if (c < 40) begin
        b_s_vld = 1'b1;
        b_oht   = 24'(rand_oht(24));
      end else begin
        b_s_vld = 1'b0;
      end
      #1;
      if (b_m_vld) begin
        chk("b_order", bexp_q.size() != 0, 1);
        if (bexp_q.size() != 0) begin
          chk("b_lat", c - stamp_q.pop_front(), 3);
          chk("b_out", obs_b(), bexp_q.pop_front());
          nb++;
        end
      end
      if (b_s_vld) begin
        chk("b_s_rdy", b_s_rdy, 1);
        if (b_s_rdy) begin
          bexp_q.push_back(ref_enc(64'(b_oht), 24));
          stamp_q.push_back(c);
        end
      end
    end
    chk("b_count", nb, 40);

    // Random valid/ready stream on the 32-bit tree.
    nin = 0; nout = 0; cyc = 0; hold_pend = 1'b0; held = '0;
    while (nout < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      a_m_rdy = ($urandom_range(0, 3) != 0);
      if (nin < 10000) begin
        a_s_vld = ($urandom_range(0, 3) != 0);
        a_oht   = 32'(rand_oht(32));
      end else begin
        a_s_vld = 1'b0;
      end
      #1;
      if (hold_pend) chk("hold", {a_m_vld, obs_a()}, {1'b1, held});
      if (a_s_vld && a_s_rdy) begin
        exp_q.push_back(ref_enc(64'(a_oht), 32));
        nin++;
      end
      if (a_m_vld && a_m_rdy) begin
        chk("stream_order", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk("stream", obs_a(), want);
        end
        nout++;
      end
      hold_pend = a_m_vld && !a_m_rdy;
      held      = obs_a();
    end
    chk("stream_cnt", nout, 10000);
    chk("stream_left", exp_q.size(), 0);
    @(negedge clk);
    a_s_vld = 1'b0;
    a_m_rdy = 1'b1;
    cnt = 0;
    repeat (8) begin
      #1;
      if (a_m_vld) cnt++;
      @(negedge clk);
    end
    chk("stream_extra", cnt, 0);

    // Reset with three items stalled in the pipe.
    a_m_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_s_vld = 1'b1;
      a_oht   = 32'd1 << (i + 3);
      @(negedge clk);
    end
    a_s_vld = 1'b0;
    repeat (6) @(negedge clk);
    chk("inflight_m_vld", a_m_vld, 1);
    chk("inflight_head", obs_a(), ref_enc(64'h8, 32));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_vld", a_m_vld, 0);
    chk("arst_out", obs_a(), 0);
    chk("arst_s_rdy", a_s_rdy, 1);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    a_m_rdy = 1'b1;
    #1;
    chk("rel2_s_rdy", a_s_rdy, 1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_m_vld) cnt++;
    end
    chk("stale", cnt, 0);
    lat_a("post_rst", 32'h0000_0400, 5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
